// File: rtl/branch_resolve_unit.sv
// Registered branch-resolution stage: evaluates all six conditional branch types,
// computes target/redirect PC, flags mispredictions and keeps saturating statistics.
module branch_resolve_unit #(
  parameter int XLEN       = 32,
  parameter int CNT_W      = 16,
  parameter int INSN_BYTES = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       funct3_i,
  input  logic [XLEN-1:0]  in_1_i,
  input  logic [XLEN-1:0]  in_2_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic             pred_taken_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             equel_o,
  output logic             taken_o,
  output logic [XLEN-1:0]  target_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic             mispredict_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] br_count_o,
  output logic [CNT_W-1:0] misp_count_o
);

  typedef struct packed {
    logic            equel;
    logic            taken;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] redirect;
    logic            mispredict;
    logic            illegal;
  } result_t;

  result_t          res_s, res_d, res_q;
  logic             out_valid_d, out_valid_q;
  logic [CNT_W-1:0] br_cnt_d, br_cnt_q, misp_cnt_d, misp_cnt_q;
  logic             eq_s, lt_s, ltu_s;
  logic [XLEN-1:0]  fall_s;
  logic             accept_s, retire_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_W'(1);
    end
  endfunction

  assign in_ready_o = !out_valid_q | out_ready_i;
  assign accept_s   = in_valid_i & in_ready_o & !flush_i;
  // A flushed result leaves without being counted.
  assign retire_s   = out_valid_q & out_ready_i & !flush_i;

  // Branch evaluation of the operation currently presented.
  always_comb begin
    eq_s   = (in_1_i == in_2_i);
    lt_s   = ($signed(in_1_i) < $signed(in_2_i));
    ltu_s  = (in_1_i < in_2_i);
    fall_s = pc_i + XLEN'(INSN_BYTES);
    res_s            = '0;
    res_s.equel      = eq_s;
    res_s.target     = pc_i + imm_i;
    case (funct3_i)
      3'b000:  res_s.taken = eq_s;
      3'b001:  res_s.taken = !eq_s;
      3'b100:  res_s.taken = lt_s;
      3'b101:  res_s.taken = !lt_s;
      3'b110:  res_s.taken = ltu_s;
      3'b111:  res_s.taken = !ltu_s;
      default: res_s.illegal = 1'b1;
    endcase
    res_s.redirect   = res_s.taken ? res_s.target : fall_s;
    res_s.mispredict = res_s.taken ^ pred_taken_i;
  end

  // Handshake, result capture and saturating statistics next-state.
  always_comb begin
    out_valid_d = out_valid_q;
    res_d       = res_q;
    br_cnt_d    = br_cnt_q;
    misp_cnt_d  = misp_cnt_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (accept_s) begin
      out_valid_d = 1'b1;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (accept_s) begin
      res_d = res_s;
    end else begin
      res_d = res_q;
    end
    if (retire_s) begin
      br_cnt_d = sat_inc(br_cnt_q);
      if (res_q.mispredict) begin
        misp_cnt_d = sat_inc(misp_cnt_q);
      end else begin
        misp_cnt_d = misp_cnt_q;
      end
    end else begin
      br_cnt_d   = br_cnt_q;
      misp_cnt_d = misp_cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      br_cnt_q    <= '0;
      misp_cnt_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      br_cnt_q    <= br_cnt_d;
      misp_cnt_q  <= misp_cnt_d;
    end
  end

  assign out_valid_o   = out_valid_q;
  assign equel_o       = res_q.equel;
  assign taken_o       = res_q.taken;
  assign target_o      = res_q.target;
  assign redirect_pc_o = res_q.redirect;
  assign mispredict_o  = res_q.mispredict;
  assign illegal_o     = res_q.illegal;
  assign br_count_o    = br_cnt_q;
  assign misp_count_o  = misp_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed vectors, handshake corner sequences and
// random traffic against a transaction-level reference model (default and CNT_W=2).
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, flush, out_ready, pred;
  logic [2:0]  funct3;
  logic [31:0] in_1, in_2, pc, imm;

  logic        in_ready, out_valid, equel, taken, misp, illegal;
  logic [31:0] target, redirect;
  logic [15:0] br_count, misp_count;
  logic        s_in_ready, s_out_valid, s_equel, s_taken, s_misp, s_illegal;
  logic [31:0] s_target, s_redirect;
  logic [1:0]  s_br, s_misp_cnt;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(32), .CNT_W(16), .INSN_BYTES(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .funct3_i(funct3), .in_1_i(in_1), .in_2_i(in_2), .pc_i(pc), .imm_i(imm),
    .pred_taken_i(pred), .flush_i(flush), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .equel_o(equel), .taken_o(taken), .target_o(target), .redirect_pc_o(redirect),
    .mispredict_o(misp), .illegal_o(illegal), .br_count_o(br_count), .misp_count_o(misp_count)
  );

  branch_resolve_unit #(.XLEN(32), .CNT_W(2), .INSN_BYTES(4)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(s_in_ready),
    .funct3_i(funct3), .in_1_i(in_1), .in_2_i(in_2), .pc_i(pc), .imm_i(imm),
    .pred_taken_i(pred), .flush_i(flush), .out_valid_o(s_out_valid), .out_ready_i(out_ready),
    .equel_o(s_equel), .taken_o(s_taken), .target_o(s_target), .redirect_pc_o(s_redirect),
    .mispredict_o(s_misp), .illegal_o(s_illegal), .br_count_o(s_br), .misp_count_o(s_misp_cnt)
  );

  typedef struct {
    logic        equel;
    logic        taken;
    logic [31:0] target;
    logic [31:0] redirect;
    logic        misp;
    logic        illegal;
  } res_t;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a, b, pc, imm;
    logic        pred;
    res_t        exp;
  } vec_t;

  vec_t vecs[12];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: one result slot plus unbounded retire counts.
  logic m_valid;
  res_t m_res;
  int   br_raw, misp_raw;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic res_t ref_resolve(input logic [2:0] f, input logic [31:0] a, b, p, im,
                                       input logic pr);
    res_t r;
    longint sa, sb;
    longint unsigned ua, ub, sum, fall;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ua   = 64'(a);
    ub   = 64'(b);
    sum  = 64'(p) + 64'(im);
    fall = 64'(p) + 64'd4;
    r.equel   = (a == b);
    r.taken   = 1'b0;
    r.illegal = 1'b0;
    case (f)
      3'd0:    r.taken = (a == b);
      3'd1:    r.taken = (a != b);
      3'd4:    r.taken = (sa < sb);
      3'd5:    r.taken = (sa >= sb);
      3'd6:    r.taken = (ua < ub);
      3'd7:    r.taken = (ua >= ub);
      default: r.illegal = 1'b1;
    endcase
    r.target   = sum[31:0];
    r.redirect = r.taken ? sum[31:0] : fall[31:0];
    r.misp     = (r.taken != pr);
    return r;
  endfunction

  task automatic model_reset();
    m_valid  = 1'b0;
    m_res    = '{default: '0};
    br_raw   = 0;
    misp_raw = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_valid"}, out_valid, m_valid);
    chk({tag, ".s_out_valid"}, s_out_valid, m_valid);
    if (m_valid) begin
      chk({tag, ".equel"}, equel, m_res.equel);
      chk({tag, ".taken"}, taken, m_res.taken);
      chk({tag, ".target"}, target, m_res.target);
      chk({tag, ".redirect"}, redirect, m_res.redirect);
      chk({tag, ".misp"}, misp, m_res.misp);
      chk({tag, ".illegal"}, illegal, m_res.illegal);
      chk({tag, ".s_result"}, {s_equel, s_taken, s_target, s_redirect, s_misp, s_illegal},
          {m_res.equel, m_res.taken, m_res.target, m_res.redirect, m_res.misp, m_res.illegal});
    end
    chk({tag, ".br_count"}, br_count, sat(br_raw, 65535));
    chk({tag, ".misp_count"}, misp_count, sat(misp_raw, 65535));
    chk({tag, ".s_br_count"}, s_br, sat(br_raw, 3));
    chk({tag, ".s_misp_count"}, s_misp_cnt, sat(misp_raw, 3));
  endtask

  // One clock: drive at negedge, check ready, advance model, check outputs next negedge.
  task automatic cycle(input logic v, input logic [2:0] f, input logic [31:0] a, b, p, im,
                       input logic pr, input logic fl, input logic rdy, input string tag);
    logic exp_rdy, acc;
    in_valid = v; funct3 = f; in_1 = a; in_2 = b; pc = p; imm = im;
    pred = pr; flush = fl; out_ready = rdy;
    #1;
    exp_rdy = !m_valid || rdy;
    chk({tag, ".in_ready"}, in_ready, exp_rdy);
    chk({tag, ".s_in_ready"}, s_in_ready, exp_rdy);
    acc = v && exp_rdy && !fl;
    if (m_valid && rdy && !fl) begin
      br_raw++;
      if (m_res.misp) misp_raw++;
    end
    if (fl) m_valid = 1'b0;
    else if (acc) begin
      m_valid = 1'b1;
      m_res   = ref_resolve(f, a, b, p, im, pr);
    end else if (rdy) m_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_vec(input int i, input logic [2:0] f, input logic [31:0] a, b, p, im,
                         input logic pr, input logic eq, tk, input logic [31:0] tg, rd,
                         input logic mp, il);
    vecs[i].f = f; vecs[i].a = a; vecs[i].b = b; vecs[i].pc = p; vecs[i].imm = im;
    vecs[i].pred = pr;
    vecs[i].exp.equel = eq; vecs[i].exp.taken = tk; vecs[i].exp.target = tg;
    vecs[i].exp.redirect = rd; vecs[i].exp.misp = mp; vecs[i].exp.illegal = il;
  endtask

  initial begin
    logic [31:0] snap_tgt, a, b;
    logic [15:0] snap_br;
    string       t;

    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; pred = 1'b0;
    funct3 = 3'd0; in_1 = 32'd0; in_2 = 32'd0; pc = 32'd0; imm = 32'd0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.result", {equel, taken, misp, illegal, target, redirect}, 68'd0);
    chk("rst.counters", {br_count, misp_count}, 32'd0);
    chk("rst.in_ready", in_ready, 1'b1);
    rst_n = 1'b1;

    //        idx f       in_1          in_2          pc            imm           pr eq tk target        redirect      mp il
    set_vec(0,  3'b000, 32'h00001001, 32'h00001001, 32'h00000100, 32'h00000020, 0, 1, 1, 32'h00000120, 32'h00000120, 1, 0);
    set_vec(1,  3'b001, 32'h00001011, 32'h00001001, 32'h00000100, 32'h00000020, 1, 0, 1, 32'h00000120, 32'h00000120, 0, 0);
    set_vec(2,  3'b000, 32'h00001011, 32'h00001001, 32'h00000100, 32'h00000020, 1, 0, 0, 32'h00000120, 32'h00000104, 1, 0);
    set_vec(3,  3'b100, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFC, 32'h00000008, 1, 0, 1, 32'h00000004, 32'h00000004, 0, 0);
    set_vec(4,  3'b110, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFC, 32'h00000008, 1, 0, 0, 32'h00000004, 32'h00000000, 1, 0);
    set_vec(5,  3'b101, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFC, 32'h00000008, 0, 0, 0, 32'h00000004, 32'h00000000, 0, 0);
    set_vec(6,  3'b111, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFC, 32'h00000008, 0, 0, 1, 32'h00000004, 32'h00000004, 1, 0);
    set_vec(7,  3'b010, 32'h00000005, 32'h00000005, 32'h00000200, 32'h00000040, 1, 1, 0, 32'h00000240, 32'h00000204, 1, 1);
    set_vec(8,  3'b011, 32'h00000001, 32'h00000002, 32'h00000200, 32'h00000040, 0, 0, 0, 32'h00000240, 32'h00000204, 0, 1);
    set_vec(9,  3'b101, 32'h00000007, 32'h00000007, 32'h00000300, 32'hFFFFFFF0, 1, 1, 1, 32'h000002F0, 32'h000002F0, 0, 0);
    set_vec(10, 3'b100, 32'h80000000, 32'h7FFFFFFF, 32'h00000000, 32'h00000010, 0, 0, 1, 32'h00000010, 32'h00000010, 1, 0);
    set_vec(11, 3'b110, 32'h80000000, 32'h7FFFFFFF, 32'h00000000, 32'h00000010, 0, 0, 0, 32'h00000010, 32'h00000004, 0, 0);

    for (int i = 0; i < 12; i++) begin
      t = $sformatf("vec%0d", i);
      cycle(1'b1, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].pc, vecs[i].imm, vecs[i].pred,
            1'b0, 1'b1, t);
      chk({t, ".tbl_equel"}, equel, vecs[i].exp.equel);
      chk({t, ".tbl_taken"}, taken, vecs[i].exp.taken);
      chk({t, ".tbl_target"}, target, vecs[i].exp.target);
      chk({t, ".tbl_redirect"}, redirect, vecs[i].exp.redirect);
      chk({t, ".tbl_misp"}, misp, vecs[i].exp.misp);
      chk({t, ".tbl_illegal"}, illegal, vecs[i].exp.illegal);
      if (i == 1) chk("vec.misp_after_handshake", misp_count, 16'd1);
    end
    cycle(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, "drain");

    // Stall for three cycles with a second op waiting, then release.
    cycle(1'b1, 3'b000, 32'd5, 32'd5, 32'h1000, 32'h80, 1'b1, 1'b0, 1'b1, "stallA");
    snap_tgt = target;
    snap_br  = br_count;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 3'b110, 32'd2, 32'd1, 32'h2000, 32'h10, 1'b0, 1'b0, 1'b0, "stall");
      chk("stall.target_held", target, snap_tgt);
      chk("stall.br_held", br_count, snap_br);
    end
    cycle(1'b1, 3'b110, 32'd2, 32'd1, 32'h2000, 32'h10, 1'b0, 1'b0, 1'b1, "release");
    chk("release.out_valid", out_valid, 1'b1);
    chk("release.redirect", redirect, 32'h2004);
    chk("release.br", br_count, snap_br + 16'd1);

    // Flush with a valid result being consumed and a new op presented.
    snap_br = br_count;
    cycle(1'b1, 3'b000, 32'd1, 32'd1, 32'h3000, 32'h4, 1'b0, 1'b1, 1'b1, "flush");
    chk("flush.out_valid", out_valid, 1'b0);
    chk("flush.br", br_count, snap_br);
    cycle(1'b1, 3'b000, 32'd1, 32'd1, 32'h3000, 32'h4, 1'b0, 1'b1, 1'b0, "flush2");

    // Six mispredicted branches: the 2-bit counters must pin at 3.
    do_reset();
    for (int k = 0; k < 6; k++)
      cycle(1'b1, 3'b000, 32'd9, 32'd9, 32'h400, 32'h8, 1'b0, 1'b0, 1'b1, "sat");
    cycle(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, "sat_drain");
    chk("sat.s_br", s_br, 2'd3);
    chk("sat.s_misp", s_misp_cnt, 2'd3);
    chk("sat.br16", br_count, 16'd6);

    // Asynchronous reset while stalled.
    cycle(1'b1, 3'b001, 32'd1, 32'd2, 32'h500, 32'h20, 1'b1, 1'b0, 1'b1, "pre_rst");
    cycle(1'b1, 3'b001, 32'd3, 32'd4, 32'h600, 32'h20, 1'b1, 1'b0, 1'b0, "pre_rst_stall");
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", out_valid, 1'b0);
    chk("midrst.result", {equel, taken, misp, illegal, target, redirect}, 68'd0);
    chk("midrst.counters", {br_count, misp_count, s_br, s_misp_cnt}, 36'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 400; k++) begin
      a = $urandom;
      if ($urandom_range(0, 2) == 0) a = 32'h80000000 ^ 32'($urandom_range(0, 3));
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      cycle(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), a, b, $urandom, $urandom,
            1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 3) != 0), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
